digit2num: RTL and testbench

//  Converts NUM_DIGITS packed decimal digits (one per byte, low nibble = BCD value) to an unsigned binary number.

---
 rtl/digit2num.sv | 82 ++++++++
 tb/tb_digit2num.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/digit2num.sv
// digit2num: packed BCD digits (one per byte) to unsigned binary by reverse double dabble.
// Defining DIGIT_CHECK_EN adds digit_err and rejects starts that carry a non-BCD digit.
module digit2num #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 28
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*NUM_DIGITS-1:0] digits_in,
    input  logic                    conv_start,
    output logic                    conv_busy,
    output logic                    conv_done,
    output logic [BIN_WIDTH-1:0]    num_out
`ifdef DIGIT_CHECK_EN
    ,
    output logic                    digit_err
`endif
);
    localparam int W  = 4*NUM_DIGITS;
    localparam int CW = $clog2(W+1);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] bcd, bin, bcd_load, bcd_sh, bcd_step;
    logic [CW-1:0] cnt;
    logic accept, bad;
    logic unused_hi;
    assign unused_hi = ^digits_in;
    assign accept = state == IDLE && conv_start;
    assign bcd_sh = {1'b0, bcd[W-1:1]};
    // Each nibble is corrected on its own after the shift; no carry crosses nibbles.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
        assign bcd_load[4*i +: 4] = digits_in[8*i +: 4];
        assign bcd_step[4*i +: 4] = bcd_sh[4*i+3] ? bcd_sh[4*i +: 4] - 4'd3 : bcd_sh[4*i +: 4];
    end
`ifdef DIGIT_CHECK_EN
    logic [NUM_DIGITS-1:0] nib_bad;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_chk
        assign nib_bad[i] = digits_in[8*i +: 4] > 4'd9;
    end
    assign bad = |nib_bad;
`else
    assign bad = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (accept ? (bad ? DONE : CONV) : IDLE) :
                   state == CONV ? (cnt == CW'(1) ? DONE : CONV) : IDLE;
    end
    always_comb begin
        conv_busy = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            bcd       <= '0;
            bin       <= '0;
            cnt       <= '0;
            conv_done <= 1'b0;
            num_out   <= '0;
        end else begin
            conv_done <= state == DONE;
            if (accept) begin
                bcd <= bcd_load;
                bin <= '0;
                cnt <= CW'(W);
            end else if (state == CONV) begin
                bcd <= bcd_step;
                bin <= {bcd[0], bin[W-1:1]};
                cnt <= cnt - CW'(1);
            end
            if (state == DONE) num_out <= BIN_WIDTH'(bin);
        end
    end
`ifdef DIGIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset)      digit_err <= 1'b0;
        else if (accept) digit_err <= bad;
    end
`endif
endmodule

// File: tb/tb_digit2num.sv
// tb_digit2num: directed vectors; a scoreboard queue is checked by a monitor on every conv_done.
module tb_digit2num;
    localparam int N  = 4;
    localparam int BW = 28;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic conv_start = 1'b0;
    logic [8*N-1:0] digits_in = '0;
    logic conv_busy, conv_done;
    logic [BW-1:0] num_out;
`ifdef DIGIT_CHECK_EN
    logic digit_err;
`endif
    typedef struct {logic [BW-1:0] num; logic err; int at;} exp_t;
    exp_t sb[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    digit2num #(.NUM_DIGITS(N), .BIN_WIDTH(BW)) dut (
        .clk(clk),
        .reset(reset),
        .digits_in(digits_in),
        .conv_start(conv_start),
        .conv_busy(conv_busy),
        .conv_done(conv_done),
        .num_out(num_out)
`ifdef DIGIT_CHECK_EN
        ,
        .digit_err(digit_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && conv_done) begin
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("num_out", int'(num_out), int'(e.num));
                check("done_cycle", cyc, e.at);
`ifdef DIGIT_CHECK_EN
                check("digit_err", int'(digit_err), int'(e.err));
`endif
            end
        end
    end

    task automatic issue(input logic [8*N-1:0] d, input logic [BW-1:0] num, input logic err, input int lat);
        @(negedge clk);
        digits_in = d;
        conv_start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{num, err, cyc + lat});
        conv_start = 1'b0;
    endtask

    task automatic run(input logic [8*N-1:0] d, input logic [BW-1:0] num, input logic err, input int lat);
        int b;
        b = 0;
        issue(d, num, err, lat);
        repeat (lat + 2) begin
            @(negedge clk);
            b += int'(conv_busy);
        end
        check("busy_cycles", b, lat);
    endtask

    initial begin
        logic [8*N-1:0] vec [3];
        logic [BW-1:0]  res [3];
        vec = '{32'h05060708, 32'h08070605, 32'h01000000};
        res = '{28'd5678, 28'd8765, 28'd1000};
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(conv_busy), 0);
        check("rst_done", int'(conv_done), 0);
        check("rst_num", int'(num_out), 0);
`ifdef DIGIT_CHECK_EN
        check("rst_err", int'(digit_err), 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        // T1..T3
        run(32'h01020304, 28'd1234, 1'b0, 17);
        run(32'h09090909, 28'd9999, 1'b0, 17);
        run(32'h00000000, 28'd0, 1'b0, 17);
        run(32'hF0F0F1F0, 28'd10, 1'b0, 17);
        check("num_held", int'(num_out), 10);
        // T4: start held high, digits scrambled during each conversion
        @(negedge clk);
        digits_in = vec[0];
        conv_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            sb.push_back('{res[k], 1'b0, cyc + 17});
            @(negedge clk);
            digits_in = 32'h09090909;
            if (k == 2) conv_start = 1'b0;
            if (k < 2) begin
                repeat (17) @(negedge clk);
                digits_in = vec[k+1];
            end
        end
        repeat (20) @(negedge clk);
        // T5: reset in the middle of a conversion
        @(negedge clk);
        digits_in = 32'h00000102;
        conv_start = 1'b1;
        @(posedge clk);
        #1;
        conv_start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", int'(conv_busy), 0);
        check("abort_done", int'(conv_done), 0);
        check("abort_num", int'(num_out), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_num_after", int'(num_out), 0);
        run(32'h00000402, 28'd42, 1'b0, 17);
`ifdef DIGIT_CHECK_EN
        // T6
        run(32'h00000A01, 28'd0, 1'b1, 1);
        repeat (3) @(negedge clk);
        check("err_held", int'(digit_err), 1);
        run(32'h00000007, 28'd7, 1'b0, 17);
        check("err_cleared", int'(digit_err), 0);
`endif
        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
